// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage definitions.
// Contains the state encodings, the default reset PC and the instruction field ranges.
`default_nettype none

package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_REQ  = 2'b01,
    FETCH_HOLD = 2'b10
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int TARGET_HI = 25;
  localparam int TARGET_LO = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;

endpackage

`default_nettype wire

// File: rtl/fetch_unit_next_pc_calc.sv
// next_pc_calc: combinational next-PC selection.
// Priority is jump, then taken beq, then pc+4.
`default_nettype none

module next_pc_calc
  import fetch_unit_pkg::*;
#(
  parameter int INSTR_LEN = 32
) (
  input  logic [INSTR_LEN-1:0]     pc,
  // Only the jump-target field is needed; the branch immediate is its low half.
  input  logic [TARGET_HI:TARGET_LO] inst,
  input  logic                     branch_flag,
  input  logic                     jump_flag,
  input  logic                     zero,
  output logic [INSTR_LEN-1:0]     next_pc
);

  logic [INSTR_LEN-1:0]     pc_plus4;
  logic [IMM_HI-IMM_LO:0]   imm;
  logic [INSTR_LEN-1:0]     branch_off;
  logic [INSTR_LEN-1:0]     jump_target;
  logic [INSTR_LEN-1:0]     branch_target;

  assign pc_plus4      = pc + INSTR_LEN'(4);
  assign imm           = inst[IMM_HI:IMM_LO];
  // Sign-extend first, then shift, so negative offsets wrap modulo 2^N.
  assign branch_off    = {{(INSTR_LEN-18){imm[15]}}, imm, 2'b00};
  assign branch_target = pc_plus4 + branch_off;
  assign jump_target   = {pc_plus4[INSTR_LEN-1 -: 4], inst, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump_flag) begin
      next_pc = jump_target;
    end else if (branch_flag && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// fetch_unit: multi-cycle MIPS instruction-fetch stage.
// Owns PC and IR, fetches over a req/ack handshake and advances the PC on pc_update.
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   INSTR_LEN = 32,
  parameter logic [INSTR_LEN-1:0] RESET_PC  = DEFAULT_RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_en,
  input  logic                 pc_update,
  input  logic                 branch_flag,
  input  logic                 jump_flag,
  input  logic                 zero,
  output logic                 imem_req,
  output logic [INSTR_LEN-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  output logic [INSTR_LEN-1:0] inst,
  output logic                 inst_valid,
  output logic [INSTR_LEN-1:0] pc,
  output logic [INSTR_LEN-1:0] pc_plus4,
  output logic                 busy
);

  fetch_state_e         state_q, state_d;
  logic [INSTR_LEN-1:0] pc_q, pc_d;
  logic [INSTR_LEN-1:0] inst_q, inst_d;
  logic                 inst_valid_q, inst_valid_d;
  logic                 imem_req_q, imem_req_d;
  logic [INSTR_LEN-1:0] next_pc;

  next_pc_calc #(
    .INSTR_LEN (INSTR_LEN)
  ) u_next_pc_calc (
    .pc          (pc_q),
    .inst        (inst_q[TARGET_HI:TARGET_LO]),
    .branch_flag (branch_flag),
    .jump_flag   (jump_flag),
    .zero        (zero),
    .next_pc     (next_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    imem_req_d   = imem_req_q;
    case (state_q)
      FETCH_IDLE: begin
        if (fetch_en) begin
          state_d    = FETCH_REQ;
          imem_req_d = 1'b1;
        end
      end
      FETCH_REQ: begin
        if (imem_ack) begin
          inst_d       = imem_rdata;
          inst_valid_d = 1'b1;
          imem_req_d   = 1'b0;
          state_d      = FETCH_HOLD;
        end
      end
      FETCH_HOLD: begin
        if (pc_update) begin
          pc_d         = next_pc;
          inst_valid_d = 1'b0;
          state_d      = FETCH_IDLE;
        end
      end
      default: begin
        state_d    = FETCH_IDLE;
        imem_req_d = 1'b0;
      end
    endcase
  end

  // Async reset drops imem_req immediately; any late ack then lands in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= {RESET_PC[INSTR_LEN-1:2], 2'b00};
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      imem_req_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      imem_req_q   <= imem_req_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = {pc_q[INSTR_LEN-1:2], 2'b00};
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_q + INSTR_LEN'(4);
  assign busy       = (state_q == FETCH_REQ);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven next-PC vectors plus directed fetch sequences.
`default_nettype none

module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_en = 1'b0, pc_update = 1'b0;
  logic        branch_flag = 1'b0, jump_flag = 1'b0, zero = 1'b0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic [31:0] inst, pc, pc_plus4;
  logic        inst_valid, busy;

  logic [31:0] n_pc = 32'h0, n_inst = 32'h0, n_next;
  logic        n_br = 1'b0, n_j = 1'b0, n_z = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .pc_update(pc_update),
    .branch_flag(branch_flag), .jump_flag(jump_flag), .zero(zero),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
    .pc(pc), .pc_plus4(pc_plus4), .busy(busy)
  );

  next_pc_calc u_npc (
    .pc(n_pc), .inst(n_inst[25:0]), .branch_flag(n_br), .jump_flag(n_j),
    .zero(n_z), .next_pc(n_next)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        br;
    logic        j;
    logic        z;
    logic [31:0] exp;
  } npc_vec_t;

  npc_vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch at exp_addr; poke drives ignored controls while the request waits.
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] rdata,
                          input int waits, input bit poke);
    int req_cycles;
    req_cycles = 0;
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    for (int w = 0; w < waits; w++) begin
      chk("req_wait", imem_req, 1);
      chk("addr_wait", imem_addr, exp_addr);
      chk("busy_wait", busy, 1);
      chk("valid_wait", inst_valid, 0);
      if (imem_req) req_cycles++;
      if (poke) begin
        pc_update = 1'b1; fetch_en = 1'b1; jump_flag = 1'b1;
      end
      step();
      pc_update = 1'b0; fetch_en = 1'b0; jump_flag = 1'b0;
    end
    chk("req_ack", imem_req, 1);
    chk("addr_ack", imem_addr, exp_addr);
    chk("busy_ack", busy, 1);
    if (imem_req) req_cycles++;
    chk("req_cycles", req_cycles, waits + 1);
    imem_ack = 1'b1;
    imem_rdata = rdata;
    step();
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    chk("inst_load", inst, rdata);
    chk("valid_load", inst_valid, 1);
    chk("req_drop", imem_req, 0);
    chk("busy_hold", busy, 0);
    chk("pc_fetch", pc, exp_addr);
  endtask

  task automatic complete(input logic br, input logic j, input logic z, input logic [31:0] exp_pc);
    branch_flag = br; jump_flag = j; zero = z; pc_update = 1'b1;
    step();
    branch_flag = 1'b0; jump_flag = 1'b0; zero = 1'b0; pc_update = 1'b0;
    chk("pc_next", pc, exp_pc);
    chk("valid_clr", inst_valid, 0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0010, 32'h1000_FFFF, 1'b1, 1'b0, 1'b1, 32'h0000_0010};
    vecs[1] = '{32'h0000_0010, 32'h1000_FFFF, 1'b1, 1'b0, 1'b0, 32'h0000_0014};
    vecs[2] = '{32'h4000_0008, 32'h0800_0100, 1'b1, 1'b1, 1'b1, 32'h4000_0400};
    vecs[3] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[4] = '{32'hFFFF_FFFC, 32'h03FF_FFFF, 1'b0, 1'b1, 1'b0, 32'h0FFF_FFFC};
    vecs[5] = '{32'h0000_0000, 32'h1000_8000, 1'b1, 1'b0, 1'b1, 32'hFFFE_0004};
    vecs[6] = '{32'h0000_0100, 32'h1000_7FFF, 1'b1, 1'b0, 1'b1, 32'h0002_0100};
    vecs[7] = '{32'h0000_0100, 32'h1000_7FFF, 1'b0, 1'b0, 1'b1, 32'h0000_0104};
    vecs[8] = '{32'hF000_0000, 32'h0BFF_FFFF, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC};
    vecs[9] = '{32'h7FFF_FFFC, 32'h1000_0001, 1'b1, 1'b0, 1'b1, 32'h8000_0004};

    for (int i = 0; i < 10; i++) begin
      n_pc = vecs[i].pc; n_inst = vecs[i].inst;
      n_br = vecs[i].br; n_j = vecs[i].j; n_z = vecs[i].z;
      #1;
      chk($sformatf("npc_vec%0d", i), n_next, vecs[i].exp);
    end

    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pc_plus4", pc_plus4, 32'h4);
    rst_n = 1'b1;
    step();

    // Zero-wait fetch at 0, then a plain advance.
    do_fetch(32'h0, 32'h2001_0005, 0, 1'b0);
    complete(1'b0, 1'b0, 1'b0, 32'h4);

    // Ack and pc_update while idle must both be ignored.
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    pc_update = 1'b1; jump_flag = 1'b1;
    step();
    imem_ack = 1'b0; imem_rdata = 32'h0; pc_update = 1'b0; jump_flag = 1'b0;
    chk("idle_ack_inst", inst, 32'h2001_0005);
    chk("idle_ack_valid", inst_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_pc", pc, 32'h4);

    // Three wait states with ignored controls, then a jump to 0x10.
    do_fetch(32'h4, 32'h0800_0004, 3, 1'b1);
    complete(1'b0, 1'b1, 1'b0, 32'h10);

    do_fetch(32'h10, 32'h1000_FFFF, 0, 1'b0);
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    chk("hold_fetch_req", imem_req, 0);
    chk("hold_fetch_busy", busy, 0);
    chk("hold_inst", inst, 32'h1000_FFFF);
    complete(1'b1, 1'b0, 1'b1, 32'h10);
    do_fetch(32'h10, 32'h1000_FFFF, 1, 1'b0);
    complete(1'b1, 1'b0, 1'b0, 32'h14);

    // Negative branch wraps below zero, then pc+4 wraps back to zero.
    do_fetch(32'h14, 32'h1000_FFF9, 0, 1'b0);
    complete(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'h0);
    do_fetch(32'hFFFF_FFFC, 32'h0000_0020, 0, 1'b0);
    complete(1'b0, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a request, then a late ack.
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    chk("pre_rst_req", imem_req, 1);
    chk("pre_rst_addr", imem_addr, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", imem_req, 0);
    chk("async_busy", busy, 0);
    chk("async_pc", pc, 32'h0);
    chk("async_inst", inst, 32'h0);
    chk("async_valid", inst_valid, 0);
    step();
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    step();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    chk("late_ack_inst", inst, 32'h0);
    chk("late_ack_valid", inst_valid, 0);
    chk("late_ack_busy", busy, 0);
    chk("late_ack_req", imem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the multi-cycle MIPS core. It sits directly upstream of the control unit and the datapath.
- Holds the PC and the instruction register (IR) and fetches words from instruction memory over a req/ack handshake.
- Presents the latched instruction to the control unit.
- At the end of each instruction it computes the next PC from the control unit's branch_flag/jump_flag and the ALU zero flag.

Parameters:
- INSTR_LEN, 32, instruction and PC width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- fetch_en  in  1  control unit is in IF state; request a fetch at the current PC.
- pc_update  in  1  single-cycle strobe from the control unit: instruction complete, advance the PC.
- branch_flag  in  1  current instruction is beq.
- jump_flag  in  1  current instruction is j.
- zero  in  1  ALU zero flag, sampled only with pc_update.
- imem_req  out  1  instruction-memory request.
- imem_addr  out  INSTR_LEN  word-aligned fetch address.
- imem_ack  in  1  memory response valid; imem_rdata valid in the same cycle.
- imem_rdata  in  INSTR_LEN  fetched word.
- inst  out  INSTR_LEN  instruction register, feeding the control unit and the register-file addresses.
- inst_valid  out  1  inst holds the word fetched at pc.
- pc  out  INSTR_LEN  current PC.
- pc_plus4  out  INSTR_LEN  pc + 4, combinational.
- busy  out  1  fetch in flight (state REQ).

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC, inst = 0 (nop), inst_valid = 0.
  - imem_req = 0, state = IDLE.
  - All outputs are registered or derived from registers.
- State machine (registered state), three states: IDLE, REQ, HOLD.
  - IDLE: fetch_en=1 -> REQ. imem_req is 1 from the next cycle, imem_addr = pc.
  - REQ:
    - imem_req=1 and imem_addr stays stable until ack.
    - On imem_ack=1: inst <= imem_rdata, inst_valid <= 1, imem_req <= 0, next state HOLD.
    - Ack in the first REQ cycle is legal (zero wait states).
  - HOLD: inst is stable.
    - pc_update=1 -> pc <= next_pc, inst_valid <= 0, next state IDLE.
    - fetch_en is ignored in HOLD.
- Latency:
  - fetch_en at cycle N -> imem_req high at N+1.
  - Ack at cycle M >= N+1 -> inst and inst_valid updated at M+1.
  - Minimum fetch latency is 2 cycles.
- Next-PC computation, priority order:
  1. jump_flag: {pc_plus4[31:28], inst[25:0], 2'b00}.
  2. branch_flag & zero: pc_plus4 + (sign-extend(inst[15:0]) << 2).
  3. Otherwise: pc_plus4.
- Arithmetic and width rules:
  - All additions are modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
  - The branch offset is sign-extended before the shift; negative offsets wrap correctly.
- Boundary conditions:
  - pc_update in IDLE or REQ: ignored, no PC change.
  - fetch_en in REQ: ignored, no second request.
  - jump_flag and branch_flag both 1: jump wins.
  - branch_flag=1, zero=0: pc_plus4.
  - imem_ack while not in REQ: ignored, IR unchanged.
  - pc[1:0] is always 00; imem_addr = {pc[31:2], 2'b00}.
  - rst_n low mid-REQ: imem_req drops immediately (async). The memory must discard the pending response; a late ack after reset is ignored because the state is IDLE.
- busy = (state == REQ).

Decomposition:
- Shared definitions, in the shared defines file:
  - FETCH_IDLE/FETCH_REQ/FETCH_HOLD state encodings (2 bits).
  - Default RESET_PC.
  - Existing OPCODE/IMM/TARGET field ranges, reused for inst slicing.
- One combinational sub-module, next_pc_calc (inputs pc, inst, branch_flag, jump_flag, zero; output next_pc).
  - Kept separate so the verification engineer can exhaustively check the target arithmetic.

Test Plan:
- Reset, then fetch_en=1 with ack in the first REQ cycle and rdata=32'h2001_0005 -> imem_addr=0 and req for 1 cycle; inst=32'h2001_0005 and inst_valid=1 two cycles after fetch_en.
- 3 wait states -> imem_req held 4 cycles with stable addr; busy=1 throughout; IR loads on the ack cycle +1.
- pc=0x0000_0010, inst imm=16'hFFFF, branch_flag=1, zero=1, pc_update -> pc=0x0000_0010. With zero=0 -> pc=0x0000_0014.
- pc=0x4000_0008, inst=32'h0800_0100 (j), jump_flag=1 and branch_flag=1 -> pc=0x4000_0400.
- pc=0xFFFF_FFFC, plain pc_update -> pc=0; next fetch uses imem_addr=0.
- rst_n low during REQ, then a late ack with rdata=32'hDEAD_BEEF -> req=0 immediately, pc=RESET_PC, inst=0, inst_valid stays 0.
